ps2_key_event_rx: RTL and testbench
===================================

PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter FILTER_REPEAT, default 1, 1 = suppress typematic repeat makes.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk/ps2_data (>=2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 5000, idle clk cycles before a partial frame is abandoned.
REQ-005 clk  input  1  system clock; sole clock, all flops rising-edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 ps2_clk  input  1  raw PS/2 clock from keyboard.
REQ-008 ps2_data  input  1  raw PS/2 data from keyboard.
REQ-009 evt_ready  input  1  consumer accepts head event.
REQ-010 evt_valid  output  1  FIFO non-empty; head event presented.
REQ-011 evt_code  output  8  head scan code (0 when empty).
REQ-012 evt_ext  output  1  head event had E0 prefix (0 when empty).
REQ-013 evt_break  output  1  head event is release (0 when empty).
REQ-014 overflow  output  1  sticky: an event was dropped on full FIFO.
REQ-015 parity_err  output  1  one-cycle pulse per rejected frame.
REQ-016 press_cnt  output  8  count of make events written to FIFO, wraps 255->0.

Function
REQ-017 SHALL pass ps2_clk/ps2_data through SYNC_STAGES flops; a falling edge is synchronised ps2_clk 1->0 between consecutive cycles.
REQ-018 SHALL sample synchronised ps2_data on each falling edge into 11-bit frame: start(0), data[7:0] LSB first, odd parity, stop(1); bit counter 0..10.
REQ-019 Frame valid iff start==0, stop==1, XOR(data,parity)==1; else parity_err pulses 1 cycle after stop edge, frame discarded, decoder state unchanged.
REQ-020 Bit counter nonzero and no falling edge for TIMEOUT_CYC cycles -> counter returns to 0, partial frame discarded silently (no parity_err).
REQ-021 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; advanced once per valid byte.
REQ-022 Byte E0 -> EXT from any state.
REQ-023 Byte F0: IDLE->BRK, EXT->EXT_BRK, BRK/EXT_BRK unchanged.
REQ-024 Other byte: forms event {ext = state in EXT/EXT_BRK, break = state in BRK/EXT_BRK, code}, FSM -> IDLE.
REQ-025 Held-key register {valid, ext, code}: make of non-held key loads it; break matching held key clears valid; other breaks leave it.
REQ-026 FILTER_REPEAT=1: make matching valid held key discarded (no push, no press_cnt change); FILTER_REPEAT=0: all makes pushed.
REQ-027 Latency: stop-bit edge detected cycle E -> event written at end of E+1 -> evt_valid high from E+2 if FIFO was empty.
REQ-028 Pop on evt_valid && evt_ready; evt_* show next entry (or 0s) next cycle; FIFO ordering strict.
REQ-029 Push when full without same-cycle pop: event dropped, overflow set, press_cnt unchanged.
REQ-030 Push and pop same cycle when full: both succeed, overflow unaffected; when empty, pop ignored (evt_valid 0).
REQ-031 press_cnt increments in the cycle a make event is written; overflow clears only on reset.

Reset
REQ-032 rst_n low at a clk edge: evt_valid/evt_code/evt_ext/evt_break/overflow/parity_err/press_cnt = 0, FIFO empty, FSM IDLE, held-key invalid, bit counter 0, timeout counter 0, synchronisers to 1.
REQ-033 Reset mid-frame discards partial frame; first frame after release decodes normally.

Verification
REQ-034 Send 1C, F0 1C, 1B,1B,1B, F0 1B, evt_ready=1, FILTER_REPEAT=1 -> events {0,0,1C},{0,1,1C},{0,0,1B},{0,1,1B}; press_cnt=2; same with FILTER_REPEAT=0 -> six events, press_cnt=4.
REQ-035 Send E0 75, E0 F0 75 -> {ext=1,brk=0,75},{ext=1,brk=1,75}.
REQ-036 Send 1C with wrong parity -> parity_err 1-cycle pulse, no event, FSM remains IDLE; following F0 1C yields {0,1,1C}.
REQ-037 evt_ready=0, send 9 distinct makes, FIFO_DEPTH=8 -> first 8 stored, overflow=1, press_cnt=8; drain yields them in order.
REQ-038 Stop ps2_clk after 5 bits, wait TIMEOUT_CYC+1 cycles, send 1B -> single event {0,0,1B}, no parity_err.
REQ-039 Assert rst_n low mid-frame and with 3 queued events -> all outputs 0 next cycle; next full 1C frame -> {0,0,1C}, press_cnt=1.

Source files
------------

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: turns raw PS/2 clock/data into key make/break events
// and queues them in a small FIFO for a ready/valid consumer.
module ps2_key_event_rx #(
  parameter int FIFO_DEPTH    = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_CYC   = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       overflow,
  output logic       parity_err,
  output logic [7:0] press_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, data_s;

  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] idle_cnt;
  logic          frame_ok;
  logic          byte_valid;
  logic [7:0]    byte_q;

  dec_state_t state, state_nxt;
  logic       ev_push, ev_ext, ev_brk;

  logic       held_valid, held_ext;
  logic [7:0] held_code;
  logic       held_match, is_make, filtered, fifo_wr_req;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, do_pop, do_push;
  logic [9:0]  head;

  // Bring the asynchronous PS/2 lines into the clk domain and remember the last clock level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // When the stop bit arrives, shift holds {parity, data[7:0], start} and data_s is the stop bit
  assign frame_ok = ~shift[0] & data_s & (^shift[9:1]);

  // Frame assembly: shift bits in on falling edges, validate at the stop bit, abandon stalled frames
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift      <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_q     <= '0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_q     <= shift[8:1];
          end else begin
            parity_err <= 1'b1;
          end
        end else begin
          shift   <= {data_s, shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Prefix decoder state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Prefix decoder: E0/F0 only move the state, any other byte emits an event and returns to idle
  always_comb begin
    state_nxt = state;
    ev_push   = 1'b0;
    ev_ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
    ev_brk    = (state == ST_BRK) || (state == ST_EXT_BRK);
    if (byte_valid) begin
      if (byte_q == 8'hE0) begin
        state_nxt = ST_EXT;
      end else if (byte_q == 8'hF0) begin
        case (state)
          ST_IDLE: state_nxt = ST_BRK;
          ST_EXT:  state_nxt = ST_EXT_BRK;
          default: state_nxt = state;
        endcase
      end else begin
        ev_push   = 1'b1;
        state_nxt = ST_IDLE;
      end
    end
  end

  assign held_match  = held_valid && (held_ext == ev_ext) && (held_code == byte_q);
  assign is_make     = ev_push & ~ev_brk;
  assign filtered    = is_make & held_match & (FILTER_REPEAT != 0);
  assign fifo_wr_req = ev_push & ~filtered;

  // Track the most recently pressed key so typematic repeats can be recognised
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= '0;
    end else if (is_make && !held_match) begin
      held_valid <= 1'b1;
      held_ext   <= ev_ext;
      held_code  <= byte_q;
    end else if (ev_push && ev_brk && held_match) begin
      held_valid <= 1'b0;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = ~empty & evt_ready;
  assign do_push = fifo_wr_req & (~full | do_pop);

  // Event storage; contents need no reset because outputs are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {ev_ext, ev_brk, byte_q};
  end

  // FIFO pointers plus the sticky overflow flag and the make counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      press_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_wr_req && !do_push) overflow <= 1'b1;
      if (do_push && !ev_brk) press_cnt <= press_cnt + 8'd1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_valid = ~empty;
  assign evt_code  = empty ? 8'h00 : head[7:0];
  assign evt_break = empty ? 1'b0 : head[8];
  assign evt_ext   = empty ? 1'b0 : head[9];

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench for ps2_key_event_rx: two instances (repeat filter on/off)
// share the PS/2 lines and are checked against a byte-level keyboard model.
module tb_ps2_key_event_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ps2_clk, ps2_data, evt_ready;
  logic [1:0]      valid, ext, brk, ovf, perr;
  logic [1:0][7:0] code, press;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int perr_seen[2];
  int perr_exp;
  bit rand_mode;
  bit ready_req;

  bit         m_ext[2], m_brk[2], m_hv[2], m_he[2], m_ovf[2];
  logic [7:0] m_hc[2];
  int         m_press[2];

  ps2_key_event_rx #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(1), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) u_filt (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .evt_ready(evt_ready),
    .evt_valid(valid[0]), .evt_code(code[0]), .evt_ext(ext[0]), .evt_break(brk[0]),
    .overflow(ovf[0]), .parity_err(perr[0]), .press_cnt(press[0]));

  ps2_key_event_rx #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(0), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) u_raw (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .evt_ready(evt_ready),
    .evt_valid(valid[1]), .evt_code(code[1]), .evt_ext(ext[1]), .evt_break(brk[1]),
    .overflow(ovf[1]), .parity_err(perr[1]), .press_cnt(press[1]));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer handshake: either a held level or a coin flip every cycle
  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 evt_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_req;
    end
  end

  // Monitor: every accepted head event must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid[0] && evt_ready) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL evt_filt_unexpected actual=%0h required=none", {ext[0], brk[0], code[0]});
        end else checkOutput("evt_filt", {ext[0], brk[0], code[0]}, exp_q0.pop_front());
      end
      if (valid[1] && evt_ready) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL evt_raw_unexpected actual=%0h required=none", {ext[1], brk[1], code[1]});
        end else checkOutput("evt_raw", {ext[1], brk[1], code[1]}, exp_q1.pop_front());
      end
      if (perr[0]) perr_seen[0]++;
      if (perr[1]) perr_seen[1]++;
    end
  end

  // Keyboard model: prefix flags per instance, held key, bounded queue
  task automatic modelByte(input logic [7:0] b);
    for (int k = 0; k < 2; k++) begin
      bit push;
      bit match;
      int qs;
      if (b == 8'hE0) begin
        m_ext[k] = 1'b1;
        m_brk[k] = 1'b0;
      end else if (b == 8'hF0) begin
        m_brk[k] = 1'b1;
      end else begin
        push  = 1'b1;
        match = m_hv[k] && (m_he[k] == m_ext[k]) && (m_hc[k] == b);
        if (!m_brk[k]) begin
          if (match) begin
            if (k == 0) push = 1'b0;
          end else begin
            m_hv[k] = 1'b1; m_he[k] = m_ext[k]; m_hc[k] = b;
          end
        end else if (match) begin
          m_hv[k] = 1'b0;
        end
        if (push) begin
          qs = (k == 0) ? exp_q0.size() : exp_q1.size();
          if (qs >= DEPTH) m_ovf[k] = 1'b1;
          else begin
            if (k == 0) exp_q0.push_back({m_ext[k], m_brk[k], b});
            else        exp_q1.push_back({m_ext[k], m_brk[k], b});
            if (!m_brk[k]) m_press[k] = (m_press[k] + 1) % 256;
          end
        end
        m_ext[k] = 1'b0;
        m_brk[k] = 1'b0;
      end
    end
  endtask

  task automatic modelReset();
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_ext[k] = 0; m_brk[k] = 0; m_hv[k] = 0; m_he[k] = 0; m_hc[k] = '0;
      m_press[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // Drive nbits of a frame; kind 1 = bad parity, 2 = bad stop, 3 = bad start
  task automatic applyStimulus(input logic [7:0] b, input int nbits, input int kind);
    logic [10:0] fr;
    fr = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) fr[9] = ~fr[9];
    if (kind == 2) fr[10] = 1'b0;
    if (kind == 3) fr[0] = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      waitCycles(HALF / 2);
      ps2_clk = 1'b0;
      waitCycles(HALF);
      ps2_clk = 1'b1;
      waitCycles(HALF / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic sendKey(input logic [7:0] b);
    modelByte(b);
    applyStimulus(b, 11, 0);
    waitCycles(2 * HALF);
  endtask

  task automatic sendBad(input logic [7:0] b, input int kind);
    perr_exp++;
    applyStimulus(b, 11, kind);
    waitCycles(2 * HALF);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_left", exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic checkZero();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_valid%0d", k), valid[k], 0);
      checkOutput($sformatf("rst_code%0d", k), code[k], 0);
      checkOutput($sformatf("rst_ext%0d", k), ext[k], 0);
      checkOutput($sformatf("rst_brk%0d", k), brk[k], 0);
      checkOutput($sformatf("rst_ovf%0d", k), ovf[k], 0);
      checkOutput($sformatf("rst_perr%0d", k), perr[k], 0);
      checkOutput($sformatf("rst_press%0d", k), press[k], 0);
    end
  endtask

  task automatic checkCounters(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_press%0d", tag, k), press[k], m_press[k]);
      checkOutput($sformatf("%s_ovf%0d", tag, k), ovf[k], m_ovf[k]);
      checkOutput($sformatf("%s_perr%0d", tag, k), perr_seen[k], perr_exp);
    end
  endtask

  // Reset held for one edge, outputs checked in the following cycle
  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkZero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
  endtask

  // Watchdog so the run always ends
  initial begin
    #950000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios, then a randomized byte stream
  initial begin
    logic [7:0] keys[6];
    int r;
    keys = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B};
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    rand_mode = 1'b0; ready_req = 1'b1;
    perr_seen[0] = 0; perr_seen[1] = 0; perr_exp = 0;
    modelReset();
    waitCycles(3);
    doReset();
    waitCycles(4);

    $display("[TB] make/break and typematic repeat");
    sendKey(8'h1C); sendKey(8'hF0); sendKey(8'h1C);
    sendKey(8'h1B); sendKey(8'h1B); sendKey(8'h1B);
    sendKey(8'hF0); sendKey(8'h1B);
    waitDrain();
    checkCounters("repeat");

    $display("[TB] extended keys");
    sendKey(8'hE0); sendKey(8'h75);
    sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);
    waitDrain();

    $display("[TB] rejected frame");
    sendBad(8'h1C, 1);
    sendKey(8'hF0); sendKey(8'h1C);
    waitDrain();
    checkCounters("parity");

    $display("[TB] stalled partial frame");
    applyStimulus(8'h55, 5, 0);
    waitCycles(TMO + 1);
    sendKey(8'h1B);
    waitDrain();
    checkCounters("timeout");

    $display("[TB] overflow with consumer stalled");
    ready_req = 1'b0;
    for (int i = 0; i < 9; i++) sendKey(8'h10 + 8'(i));
    checkOutput("ovf_valid0", valid[0], 1);
    checkOutput("ovf_valid1", valid[1], 1);
    checkCounters("overflow");
    ready_req = 1'b1;
    waitDrain();

    $display("[TB] reset mid-frame with queued events");
    ready_req = 1'b0;
    sendKey(8'h21); sendKey(8'h22); sendKey(8'h23);
    checkOutput("pre_rst_valid0", valid[0], 1);
    checkOutput("pre_rst_valid1", valid[1], 1);
    applyStimulus(8'h1C, 6, 0);
    doReset();
    ready_req = 1'b1;
    sendKey(8'h1C);
    waitDrain();
    checkCounters("post_rst");

    $display("[TB] randomized byte stream");
    rand_mode = 1'b1;
    repeat (150) begin
      r = $urandom_range(0, 99);
      if (r < 6)       sendBad(keys[$urandom_range(0, 5)], $urandom_range(1, 3));
      else if (r < 10) begin
        applyStimulus(keys[$urandom_range(0, 5)], $urandom_range(1, 10), 0);
        waitCycles(TMO + HALF);
      end
      else if (r < 22) sendKey(8'hE0);
      else if (r < 36) sendKey(8'hF0);
      else             sendKey(keys[$urandom_range(0, 5)]);
    end
    waitDrain();
    rand_mode = 1'b0;
    waitCycles(4);
    checkCounters("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
